warp_controller: RTL and testbench
==================================

WARP_CONTROLLER -- requirements
Module: warp_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH, scalar datapath width.
REQ-002 SHALL have parameter INSTR_WIDTH, default 32, fetched instruction width.
REQ-003 SHALL have port clk  input  1  single clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  warp enable; low freezes all state.
REQ-006 SHALL have port start  input  1  launch request.
REQ-007 SHALL have port start_pc  input  instruction_memory_address_t  launch PC.
REQ-008 SHALL have port fetch_req  output  1  instruction fetch request.
REQ-009 SHALL have port fetch_valid  input  1  fetched instruction valid.
REQ-010 SHALL have port fetch_data  input  INSTR_WIDTH  fetched instruction.
REQ-011 SHALL have port instruction  output  INSTR_WIDTH  latched instruction to decoder.
REQ-012 SHALL have port decoded_mem_read / decoded_mem_write  input  1 each  memory op flags.
REQ-013 SHALL have port decoded_halt  input  1  halt instruction flag.
REQ-014 SHALL have port lsu_done  input  1  LSU completion pulse.
REQ-015 SHALL have port branch_taken  input  1  and branch_target  input  instruction_memory_address_t.
REQ-016 SHALL have port warp_state  output  warp_state_t  current state, consumed by the scalar/vector register files.
REQ-017 SHALL have port pc  output  instruction_memory_address_t  current PC.
REQ-018 SHALL have port retired_count  output  DATA_WIDTH  instructions retired.
REQ-019 SHALL have port done  output  1  warp halted.

Function
REQ-020 FSM states SHALL be WARP_IDLE, WARP_FETCH, WARP_DECODE, WARP_REQUEST, WARP_WAIT, WARP_EXECUTE, WARP_UPDATE, WARP_DONE.
REQ-021 IDLE: enable&&start -> FETCH, pc<=start_pc, retired_count<=0.
REQ-022 FETCH: fetch_req SHALL be 1 (combinational, FETCH only); fetch_valid -> latch fetch_data into instruction, go DECODE; else stay.
REQ-023 DECODE -> REQUEST unconditionally after one cycle.
REQ-024 REQUEST: decoded_mem_read||decoded_mem_write -> WAIT, else -> EXECUTE.
REQ-025 WAIT: lsu_done -> EXECUTE, else stay (no timeout).
REQ-026 EXECUTE -> UPDATE unconditionally after one cycle.
REQ-027 UPDATE: decoded_halt -> DONE, pc unchanged; else pc<=branch_taken?branch_target:pc+1 (modulo wrap), -> FETCH; retired_count SHALL increment in both cases, wrapping at 2^DATA_WIDTH.
REQ-028 DONE: done=1; start low -> IDLE (done cleared); start high -> stay.
REQ-029 Non-memory instruction with fetch_valid in first FETCH cycle SHALL take exactly 5 cycles FETCH->next FETCH.
REQ-030 enable low SHALL hold state, pc, instruction, retired_count; inputs that cycle SHALL be ignored, fetch_req SHALL be 0.
REQ-031 fetch_valid outside FETCH, lsu_done outside WAIT, start outside IDLE/DONE SHALL be ignored.
REQ-032 Branch and halt inputs SHALL be sampled only in UPDATE.

Reset
REQ-033 reset low SHALL immediately force state=WARP_IDLE, pc=0, instruction=0, retired_count=0, done=0, fetch_req=0, regardless of clk or enable.
REQ-034 Reset mid-instruction (any state, incl. WAIT) SHALL abandon it with no pc/count update; a later lsu_done SHALL be ignored.

Structure
REQ-035 warp_state_t (all eight states) and instruction_memory_address_t SHALL reside in the shared common package.
REQ-036 Single module, no sub-modules; next-state logic in one combinational block, state in one sequential block.

Verification
REQ-037 Reset low mid-EXECUTE with pc=0x12 -> state IDLE, pc=0, done=0 before next clk edge.
REQ-038 start_pc=0x10, ALU op, fetch_valid immediate -> states F,D,R,E,U, pc=0x11, retired_count=1, FETCH on cycle 6.
REQ-039 Load op, lsu_done 4 cycles after WAIT entry -> 4 WAIT cycles, then EXECUTE, pc+1.
REQ-040 UPDATE with branch_taken=1, branch_target=0x40 -> pc=0x40; pc=max address, not taken -> pc=0.
REQ-041 Halt after 3 instructions -> done=1, retired_count=3; start held high stays DONE; start low -> IDLE.
REQ-042 enable low for 3 cycles in WAIT with lsu_done pulsed -> state unchanged, pulse ignored.

Source files
------------

// File: rtl/warp_controller_pkg.sv
// Shared types for the warp controller and the register files that watch its state.
// Also supplies the default scalar datapath width when the build does not set one.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package warp_controller_pkg;

  localparam int IMEM_ADDR_WIDTH = 8;

  typedef logic [IMEM_ADDR_WIDTH-1:0] instruction_memory_address_t;

  typedef enum logic [2:0] {
    WARP_IDLE    = 3'd0,
    WARP_FETCH   = 3'd1,
    WARP_DECODE  = 3'd2,
    WARP_REQUEST = 3'd3,
    WARP_WAIT    = 3'd4,
    WARP_EXECUTE = 3'd5,
    WARP_UPDATE  = 3'd6,
    WARP_DONE    = 3'd7
  } warp_state_t;

endpackage

// File: rtl/warp_controller.sv
// Per-warp instruction sequencer: fetch, decode, optional LSU wait, execute, PC update.
// Retires one instruction per UPDATE visit and parks in DONE on a halt.
module warp_controller
  import warp_controller_pkg::*;
#(
  parameter int DATA_WIDTH  = `DATA_WIDTH,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        start,
  input  instruction_memory_address_t start_pc,
  output logic                        fetch_req,
  input  logic                        fetch_valid,
  input  logic [INSTR_WIDTH-1:0]      fetch_data,
  output logic [INSTR_WIDTH-1:0]      instruction,
  input  logic                        decoded_mem_read,
  input  logic                        decoded_mem_write,
  input  logic                        decoded_halt,
  input  logic                        lsu_done,
  input  logic                        branch_taken,
  input  instruction_memory_address_t branch_target,
  output warp_state_t                 warp_state,
  output instruction_memory_address_t pc,
  output logic [DATA_WIDTH-1:0]       retired_count,
  output logic                        done
);

  warp_state_t                 state_q, state_d;
  instruction_memory_address_t pc_q, pc_d;
  logic [INSTR_WIDTH-1:0]      instr_q, instr_d;
  logic [DATA_WIDTH-1:0]       retired_q, retired_d;

  // With enable low every register keeps its value, so all inputs are ignored.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    if (enable) begin
      case (state_q)
        WARP_IDLE: begin
          if (start) begin
            state_d   = WARP_FETCH;
            pc_d      = start_pc;
            retired_d = '0;
          end
        end
        WARP_FETCH: begin
          if (fetch_valid) begin
            instr_d = fetch_data;
            state_d = WARP_DECODE;
          end
        end
        WARP_DECODE:  state_d = WARP_REQUEST;
        WARP_REQUEST: state_d = (decoded_mem_read || decoded_mem_write) ? WARP_WAIT : WARP_EXECUTE;
        WARP_WAIT: begin
          if (lsu_done) state_d = WARP_EXECUTE;
        end
        WARP_EXECUTE: state_d = WARP_UPDATE;
        WARP_UPDATE: begin
          retired_d = retired_q + DATA_WIDTH'(1);
          if (decoded_halt) begin
            state_d = WARP_DONE;
          end else begin
            pc_d    = branch_taken ? branch_target : pc_q + instruction_memory_address_t'(1);
            state_d = WARP_FETCH;
          end
        end
        WARP_DONE: begin
          if (!start) state_d = WARP_IDLE;
        end
        default: state_d = WARP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= WARP_IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  assign fetch_req     = enable && (state_q == WARP_FETCH);
  assign done          = (state_q == WARP_DONE);
  assign warp_state    = state_q;
  assign pc            = pc_q;
  assign instruction   = instr_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_warp_controller.sv
// Directed bench for warp_controller: a per-cycle vector table plus
// hand-written asynchronous-reset sequences.
module tb_warp_controller;
  import warp_controller_pkg::*;

  localparam int DW = 32;
  localparam int IW = 32;

  logic clk = 1'b0;
  logic reset;
  logic enable, start, fetch_valid, decoded_mem_read, decoded_mem_write;
  logic decoded_halt, lsu_done, branch_taken, fetch_req, done;
  instruction_memory_address_t start_pc, branch_target, pc;
  logic [IW-1:0] fetch_data, instruction;
  logic [DW-1:0] retired_count;
  warp_state_t warp_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  warp_controller #(.DATA_WIDTH(DW), .INSTR_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .start_pc(start_pc),
    .fetch_req(fetch_req), .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .instruction(instruction), .decoded_mem_read(decoded_mem_read),
    .decoded_mem_write(decoded_mem_write), .decoded_halt(decoded_halt),
    .lsu_done(lsu_done), .branch_taken(branch_taken), .branch_target(branch_target),
    .warp_state(warp_state), .pc(pc), .retired_count(retired_count), .done(done)
  );

  typedef struct {
    logic en, st; logic [7:0] spc; logic fv; logic [31:0] fd;
    logic mr, mw, hl, lsu, bt; logic [7:0] btgt;
    warp_state_t e_state; logic [7:0] e_pc; logic [31:0] e_ret;
    logic e_done, e_freq; logic [31:0] e_instr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic en, input logic st, input logic [7:0] spc, input logic fv,
                     input logic [31:0] fd, input logic mr, input logic mw, input logic hl,
                     input logic lsu, input logic bt, input logic [7:0] btgt,
                     input warp_state_t es, input logic [7:0] ep, input logic [31:0] er,
                     input logic ed, input logic ef, input logic [31:0] ei);
    vec_t v;
    v.en = en; v.st = st; v.spc = spc; v.fv = fv; v.fd = fd; v.mr = mr; v.mw = mw;
    v.hl = hl; v.lsu = lsu; v.bt = bt; v.btgt = btgt;
    v.e_state = es; v.e_pc = ep; v.e_ret = er; v.e_done = ed; v.e_freq = ef; v.e_instr = ei;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic st, input logic [7:0] spc, input logic fv,
                       input logic [31:0] fd, input logic mr, input logic mw, input logic hl,
                       input logic lsu, input logic bt, input logic [7:0] btgt);
    enable = en; start = st; start_pc = spc; fetch_valid = fv; fetch_data = fd;
    decoded_mem_read = mr; decoded_mem_write = mw; decoded_halt = hl;
    lsu_done = lsu; branch_taken = bt; branch_target = btgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_state"}, 32'(warp_state), 32'(WARP_IDLE));
    chk({tag, "_pc"}, 32'(pc), 32'h0);
    chk({tag, "_instr"}, instruction, 32'h0);
    chk({tag, "_ret"}, retired_count, 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_freq"}, 32'(fetch_req), 32'h0);
    $display("reset %s: state=%s pc=%h ret=%0d", tag, warp_state.name(), pc, retired_count);
  endtask

  // Launch at spc, take one instruction through REQUEST (mem op or not).
  task automatic launch_to_request_exit(input logic [7:0] spc, input logic mem);
    drive(1, 1, spc, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 32'h1234_5678, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, mem, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #2;
    chk_reset_state("por");
    @(negedge clk);
    reset = 1'b1;
    #1;

    //   en st spc    fv fd            mr mw hl ls bt tgt    state         pc     ret  dn fq instr
    add(1, 1, 8'h10, 0, 32'h0,        0, 0, 0, 0, 0, 8'h00, WARP_FETCH,   8'h10, 0, 0, 1, 32'h0);
    add(1, 0, 8'h00, 1, 32'hA1,       0, 0, 0, 0, 0, 8'h00, WARP_DECODE,  8'h10, 0, 0, 0, 32'hA1);
    add(1, 0, 8'h00, 0, 32'h0,        0, 0, 0, 0, 0, 8'h00, WARP_REQUEST, 8'h10, 0, 0, 0, 32'hA1);
    add(1, 0, 8'h00, 1, 32'hEE,       0, 0, 0, 0, 0, 8'h00, WARP_EXECUTE, 8'h10, 0, 0, 0, 32'hA1);
    add(1, 0, 8'h00, 0, 32'h0,        0, 0, 0, 1, 0, 8'h00, WARP_UPDATE,  8'h10, 0, 0, 0, 32'hA1);
    add(1, 0, 8'h00, 0, 32'h0,        0, 0, 0, 0, 0, 8'h00, WARP_FETCH,   8'h11, 1, 0, 1, 32'hA1);
    // load: four WAIT cycles, lsu_done on the fifth, then branch to 0x40
    add(1, 0, 8'h00, 1, 32'hB2,       0, 0, 0, 0, 0, 8'h00, WARP_DECODE,  8'h11, 1, 0, 0, 32'hB2);
    add(1, 0, 8'h00, 0, 32'h0,        0, 0, 0, 0, 0, 8'h00, WARP_REQUEST, 8'h11, 1, 0, 0, 32'hB2);
    add(1, 0, 8'h00, 0, 32'h0,        1, 0, 0, 0, 0, 8'h00, WARP_WAIT,    8'h11, 1, 0, 0, 32'hB2);
    add(1, 1, 8'h33, 0, 32'h0,        0, 0, 0, 0, 0, 8'h00, WARP_WAIT,    8'h11, 1, 0, 0, 32'hB2);
    add(1, 0, 8'h00, 0, 32'h0,        0, 0, 0, 0, 0, 8'h00, WARP_WAIT,    8'h11, 1, 0, 0, 32'hB2);
    add(1, 0, 8'h00, 0, 32'h0,        0, 0, 0, 0, 0, 8'h00, WARP_WAIT,    8'h11, 1, 0, 0, 32'hB2);
    add(1, 0, 8'h00, 0, 32'h0,        0, 0, 0, 1, 0, 8'h00, WARP_EXECUTE, 8'h11, 1, 0, 0, 32'hB2);
    add(1, 0, 8'h00, 0, 32'h0,        0, 0, 0, 0, 0, 8'h00, WARP_UPDATE,  8'h11, 1, 0, 0, 32'hB2);
    add(1, 0, 8'h00, 0, 32'h0,        0, 0, 0, 0, 1, 8'h40, WARP_FETCH,   8'h40, 2, 0, 1, 32'hB2);
    // enable low in FETCH, then a store frozen in WAIT while lsu_done pulses
    add(0, 0, 8'h00, 1, 32'h99,       0, 0, 0, 0, 0, 8'h00, WARP_FETCH,   8'h40, 2, 0, 0, 32'hB2);
    add(1, 0, 8'h00, 1, 32'hC3,       0, 0, 0, 0, 0, 8'h00, WARP_DECODE,  8'h40, 2, 0, 0, 32'hC3);
    add(1, 0, 8'h00, 0, 32'h0,        0, 0, 1, 0, 0, 8'h00, WARP_REQUEST, 8'h40, 2, 0, 0, 32'hC3);
    add(1, 0, 8'h00, 0, 32'h0,        0, 1, 0, 0, 0, 8'h00, WARP_WAIT,    8'h40, 2, 0, 0, 32'hC3);
    add(0, 0, 8'h00, 0, 32'h0,        0, 0, 0, 1, 0, 8'h00, WARP_WAIT,    8'h40, 2, 0, 0, 32'hC3);
    add(0, 0, 8'h00, 1, 32'hFF,       0, 0, 0, 0, 0, 8'h00, WARP_WAIT,    8'h40, 2, 0, 0, 32'hC3);
    add(0, 0, 8'h00, 0, 32'h0,        0, 0, 0, 0, 0, 8'h00, WARP_WAIT,    8'h40, 2, 0, 0, 32'hC3);
    add(1, 0, 8'h00, 0, 32'h0,        0, 0, 0, 0, 0, 8'h00, WARP_WAIT,    8'h40, 2, 0, 0, 32'hC3);
    add(1, 0, 8'h00, 0, 32'h0,        0, 0, 0, 1, 0, 8'h00, WARP_EXECUTE, 8'h40, 2, 0, 0, 32'hC3);
    add(1, 0, 8'h00, 0, 32'h0,        0, 0, 0, 0, 0, 8'h00, WARP_UPDATE,  8'h40, 2, 0, 0, 32'hC3);
    // third instruction halts: pc held despite branch, count 3
    add(1, 0, 8'h00, 0, 32'h0,        0, 0, 1, 0, 1, 8'h77, WARP_DONE,    8'h40, 3, 1, 0, 32'hC3);
    add(1, 1, 8'h00, 0, 32'h0,        0, 0, 0, 0, 0, 8'h00, WARP_DONE,    8'h40, 3, 1, 0, 32'hC3);
    add(1, 1, 8'h00, 0, 32'h0,        0, 0, 0, 0, 0, 8'h00, WARP_DONE,    8'h40, 3, 1, 0, 32'hC3);
    add(1, 0, 8'h00, 0, 32'h0,        0, 0, 0, 0, 0, 8'h00, WARP_IDLE,    8'h40, 3, 0, 0, 32'hC3);
    add(0, 1, 8'h20, 0, 32'h0,        0, 0, 0, 0, 0, 8'h00, WARP_IDLE,    8'h40, 3, 0, 0, 32'hC3);
    // relaunch at the top address and wrap to zero
    add(1, 1, 8'hFF, 0, 32'h0,        0, 0, 0, 0, 0, 8'h00, WARP_FETCH,   8'hFF, 0, 0, 1, 32'hC3);
    add(1, 1, 8'h00, 1, 32'hE5,       0, 0, 0, 0, 0, 8'h00, WARP_DECODE,  8'hFF, 0, 0, 0, 32'hE5);
    add(1, 0, 8'h00, 0, 32'h0,        0, 0, 0, 0, 0, 8'h00, WARP_REQUEST, 8'hFF, 0, 0, 0, 32'hE5);
    add(1, 0, 8'h00, 0, 32'h0,        0, 0, 0, 0, 0, 8'h00, WARP_EXECUTE, 8'hFF, 0, 0, 0, 32'hE5);
    add(1, 0, 8'h00, 0, 32'h0,        0, 0, 0, 0, 0, 8'h00, WARP_UPDATE,  8'hFF, 0, 0, 0, 32'hE5);
    add(1, 0, 8'h00, 0, 32'h0,        0, 0, 0, 0, 0, 8'h00, WARP_FETCH,   8'h00, 1, 0, 1, 32'hE5);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].en, vq[i].st, vq[i].spc, vq[i].fv, vq[i].fd, vq[i].mr, vq[i].mw,
            vq[i].hl, vq[i].lsu, vq[i].bt, vq[i].btgt);
      tick();
      chk($sformatf("v%0d_state", i), 32'(warp_state), 32'(vq[i].e_state));
      chk($sformatf("v%0d_pc", i), 32'(pc), 32'(vq[i].e_pc));
      chk($sformatf("v%0d_ret", i), retired_count, vq[i].e_ret);
      chk($sformatf("v%0d_done", i), 32'(done), 32'(vq[i].e_done));
      chk($sformatf("v%0d_freq", i), 32'(fetch_req), 32'(vq[i].e_freq));
      chk($sformatf("v%0d_instr", i), instruction, vq[i].e_instr);
      $display("vec %0d: state=%s pc=%h ret=%0d done=%b freq=%b instr=%h",
               i, warp_state.name(), pc, retired_count, done, fetch_req, instruction);
    end

    // Reset mid-EXECUTE at pc 0x12, checked before the next clock edge.
    reset = 1'b0; #1; reset = 1'b1;
    launch_to_request_exit(8'h12, 1'b0);
    chk("exec_state", 32'(warp_state), 32'(WARP_EXECUTE));
    chk("exec_pc", 32'(pc), 32'h12);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_state("mid_exec");
    @(negedge clk);
    reset = 1'b1;

    // Reset mid-WAIT, then a late lsu_done must not revive the instruction.
    @(posedge clk); #1;
    launch_to_request_exit(8'h30, 1'b1);
    chk("wait_state", 32'(warp_state), 32'(WARP_WAIT));
    #2;
    reset = 1'b0;
    #1;
    chk_reset_state("mid_wait");
    @(negedge clk);
    reset = 1'b1;
    lsu_done = 1'b1;
    tick();
    lsu_done = 1'b0;
    tick();
    chk_reset_state("late_lsu");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
